// File: rtl/instr_stats.sv
// Purpose: MIPS retirement statistics: 8 counters (cycles/total/R/I/J/load/store/branch) with snapshot bank and sticky overflow.
// Latency: counters update on the clock edge; rd_data is combinational from rd_sel/rd_snap (visible the cycle after an update).
// Backpressure: none; op_valid is sampled every cycle and never stalled, controls are single-cycle pulses.
module instr_stats #(
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [5:0]       op,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             snap,
   input  logic [2:0]       rd_sel,
   input  logic             rd_snap,
   output logic [CNT_W-1:0] rd_data,
   output logic             running,
   output logic [7:0]       ovf
);

   // counter slot indices, shared with rd_sel and ovf bit positions
   localparam int IDX_CYC = 0;
   localparam int IDX_TOT = 1;
   localparam int IDX_R   = 2;
   localparam int IDX_I   = 3;
   localparam int IDX_J   = 4;
   localparam int IDX_LD  = 5;
   localparam int IDX_ST  = 6;
   localparam int IDX_BR  = 7;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt  [8];
   logic [CNT_W-1:0] r_snap [8];
   logic [CNT_W-1:0] w_cnt_nxt [8];
   logic [7:0]       r_ovf;
   logic [7:0]       w_inc;
   logic [7:0]       w_ovf_set;
   logic             w_counting;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state: clear beats stop beats start
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else if (stop) begin
         if (r_state == ST_COUNT) begin
            w_state_nxt = ST_HOLD;
         end
      end else if (start) begin
         if (r_state != ST_COUNT) begin
            w_state_nxt = ST_COUNT;
         end
      end
   end

   // a cycle counts when already in COUNT and not being cleared at this edge
   assign w_counting = (r_state == ST_COUNT) && !clear;

   // opcode classification into per-counter increment enables
   always_comb begin
      w_inc = '0;
      if (w_counting) begin
         w_inc[IDX_CYC] = 1'b1;
         if (op_valid) begin
            w_inc[IDX_TOT] = 1'b1;
            if (op == 6'b000000) begin
               w_inc[IDX_R] = 1'b1;
            end else if (op == 6'b000010 || op == 6'b000011) begin
               w_inc[IDX_J] = 1'b1;
            end else begin
               w_inc[IDX_I] = 1'b1;
            end
            case (op)
               6'b100000, 6'b100001, 6'b100011,
               6'b100100, 6'b100101:             w_inc[IDX_LD] = 1'b1;
               6'b101000, 6'b101001, 6'b101011: w_inc[IDX_ST] = 1'b1;
               6'b000001, 6'b000100, 6'b000101,
               6'b000110, 6'b000111:             w_inc[IDX_BR] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // per-counter next value, with saturate-or-wrap at all-ones
   always_comb begin
      w_ovf_set = '0;
      for (int i = 0; i < 8; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_inc[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_ovf_set[i] = 1'b1;
               w_cnt_nxt[i] = SATURATE ? CNT_MAX : '0;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // live counters and sticky overflow flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf <= '0;
      end else if (clear) begin
         for (int i = 0; i < 8; i++) begin
            r_cnt[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_ovf <= r_ovf | w_ovf_set;
      end
   end

   // snapshot bank captures pre-increment live values; clear wins over snap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            r_snap[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < 8; i++) begin
            r_snap[i] <= '0;
         end
      end else if (snap) begin
         for (int i = 0; i < 8; i++) begin
            r_snap[i] <= r_cnt[i];
         end
      end
   end

   assign rd_data = rd_snap ? r_snap[rd_sel] : r_cnt[rd_sel];
   assign running = (r_state == ST_COUNT);
   assign ovf     = r_ovf;

endmodule
